// File: rtl/word_sequencer.sv
// -----------------------------------------------------------------------------
// word_sequencer
//
// Fetches words from an external word-list ROM (one-cycle read latency) and
// presents them one character at a time. Word order is either sequential or
// pseudo-random, driven by a free-running 16-bit LFSR. Zero-length entries are
// skipped. A full pass of skips with nothing loadable returns the block to IDLE.
//
// Ports
//   clk         : clock, all state changes on rising edge
//   reset       : asynchronous, active-high
//   start       : request the next word (honoured in IDLE and DONE only)
//   abort       : return to IDLE, discarding the current word
//   mode_random : 0 = sequential order, 1 = LFSR order (sampled on advance)
//   next_char   : consume the current character (ACTIVE only)
//   rom_addr    : registered word-list address, always equal to word_index
//   rom_data    : word codes, first character in the MSBs
//   rom_len     : word length (0 = skip, > MAX_CHARS clamped)
//   cur_char    : character awaiting comparison, zero outside ACTIVE
//   chars_left  : characters remaining in the loaded word
//   num_char    : length of the loaded word
//   word_valid  : high while a word is ACTIVE
//   word_done   : one-cycle pulse after the last character is consumed
//   busy        : high in FETCH and LOAD
//   word_index  : index of the loaded or pending word
// -----------------------------------------------------------------------------
module word_sequencer #(
  parameter int CODE_W    = 8,
  parameter int MAX_CHARS = 12,
  parameter int NUM_WORDS = 32,
  parameter int ADDR_W    = $clog2(NUM_WORDS),
  parameter int LEN_W     = $clog2(MAX_CHARS + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        mode_random,
  input  logic                        next_char,
  output logic [ADDR_W-1:0]           rom_addr,
  input  logic [MAX_CHARS*CODE_W-1:0] rom_data,
  input  logic [LEN_W-1:0]            rom_len,
  output logic [CODE_W-1:0]           cur_char,
  output logic [LEN_W-1:0]            chars_left,
  output logic [LEN_W-1:0]            num_char,
  output logic                        word_valid,
  output logic                        word_done,
  output logic                        busy,
  output logic [ADDR_W-1:0]           word_index
);

  localparam int SHIFT_W = MAX_CHARS * CODE_W;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W:0]   NUM_WIDE  = (ADDR_W + 1)'(NUM_WORDS);
  localparam logic [LEN_W-1:0]  MAX_LEN   = LEN_W'(MAX_CHARS);
  localparam logic [15:0]       LFSR_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    ACTIVE,
    DONE
  } state_t;

  state_t             state_reg;
  logic [SHIFT_W-1:0] shift_reg;
  logic [15:0]        lfsr_reg;
  logic [ADDR_W-1:0]  skip_cnt_reg;

  // Next-index candidates
  logic [ADDR_W-1:0] seq_next;
  logic [ADDR_W:0]   lfsr_low;
  logic [ADDR_W:0]   lfsr_fold;
  logic [ADDR_W-1:0] lfsr_cand;
  logic [ADDR_W-1:0] adv_index;
  logic [LEN_W-1:0]  len_clamped;
  logic              lfsr_fb;

  // Fibonacci LFSR, taps 16,14,13,11 in right-shifting form.
  assign lfsr_fb = lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5];

  always_comb begin
    seq_next  = (word_index == LAST_IDX) ? '0 : word_index + 1'b1;
    lfsr_low  = {1'b0, lfsr_reg[ADDR_W-1:0]};
    // Fold out-of-range LFSR values back into the list; one subtraction is
    // enough because the low bits never reach twice NUM_WORDS.
    lfsr_fold = (lfsr_low >= NUM_WIDE) ? (lfsr_low - NUM_WIDE) : lfsr_low;
    lfsr_cand = lfsr_fold[ADDR_W-1:0];
    // A candidate equal to the current index is bumped by one; that is
    // exactly the sequential successor of the current index.
    if (mode_random) begin
      adv_index = (lfsr_cand == word_index) ? seq_next : lfsr_cand;
    end else begin
      adv_index = seq_next;
    end
    len_clamped = (rom_len > MAX_LEN) ? MAX_LEN : rom_len;
  end

  assign word_valid = (state_reg == ACTIVE);
  assign cur_char   = word_valid ? shift_reg[SHIFT_W-1 -: CODE_W] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      lfsr_reg     <= LFSR_SEED;
      skip_cnt_reg <= '0;
      chars_left   <= '0;
      num_char     <= '0;
      word_done    <= 1'b0;
      busy         <= 1'b0;
      word_index   <= '0;
      rom_addr     <= '0;
    end else begin
      lfsr_reg  <= {lfsr_fb, lfsr_reg[15:1]};
      word_done <= 1'b0;
      if (abort) begin
        state_reg  <= IDLE;
        shift_reg  <= '0;
        chars_left <= '0;
        num_char   <= '0;
        busy       <= 1'b0;
      end else begin
        case (state_reg)
          IDLE, DONE: begin
            if (start) begin
              state_reg    <= FETCH;
              busy         <= 1'b1;
              num_char     <= '0;
              skip_cnt_reg <= '0;
            end
          end
          FETCH: begin
            state_reg <= LOAD;
          end
          LOAD: begin
            if (rom_len == '0) begin
              // Empty entry: move on; give up after a full lap of skips.
              word_index <= adv_index;
              rom_addr   <= adv_index;
              if (skip_cnt_reg == LAST_IDX) begin
                state_reg <= IDLE;
                busy      <= 1'b0;
              end else begin
                skip_cnt_reg <= skip_cnt_reg + 1'b1;
                state_reg    <= FETCH;
              end
            end else begin
              shift_reg  <= rom_data;
              chars_left <= len_clamped;
              num_char   <= len_clamped;
              busy       <= 1'b0;
              state_reg  <= ACTIVE;
            end
          end
          ACTIVE: begin
            if (next_char) begin
              shift_reg  <= {shift_reg[SHIFT_W-CODE_W-1:0], {CODE_W{1'b0}}};
              chars_left <= chars_left - 1'b1;
              if (chars_left == LEN_W'(1)) begin
                state_reg  <= DONE;
                word_done  <= 1'b1;
                word_index <= adv_index;
                rom_addr   <= adv_index;
              end
            end
          end
          default: begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_word_sequencer.sv
// -----------------------------------------------------------------------------
// tb_word_sequencer
//
// Directed bench for word_sequencer. Instance dut_a uses the default 32-entry
// list with a bench-written ROM; instance dut_b uses a 24-entry list whose
// ROM returns single-character words holding their own index, so both run in
// lockstep during the random-order phase.
// -----------------------------------------------------------------------------
module tb_word_sequencer;

  localparam int CODE_W = 8;
  localparam int MAXC   = 12;
  localparam int DW     = CODE_W * MAXC;
  localparam int AW     = 5;
  localparam int LW     = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic mode_random = 1'b0;
  logic next_char = 1'b0;

  logic [AW-1:0]     rom_addr_a, rom_addr_b;
  logic [DW-1:0]     rom_data_a, rom_data_b;
  logic [LW-1:0]     rom_len_a, rom_len_b;
  logic [CODE_W-1:0] cur_char_a, cur_char_b;
  logic [LW-1:0]     chars_left_a, chars_left_b;
  logic [LW-1:0]     num_char_a, num_char_b;
  logic              word_valid_a, word_valid_b;
  logic              word_done_a, word_done_b;
  logic              busy_a, busy_b;
  logic [AW-1:0]     word_index_a, word_index_b;

  logic [DW-1:0] mem_data [0:31];
  logic [LW-1:0] mem_len  [0:31];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  word_sequencer dut_a (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .mode_random(mode_random), .next_char(next_char),
    .rom_addr(rom_addr_a), .rom_data(rom_data_a), .rom_len(rom_len_a),
    .cur_char(cur_char_a), .chars_left(chars_left_a), .num_char(num_char_a),
    .word_valid(word_valid_a), .word_done(word_done_a), .busy(busy_a),
    .word_index(word_index_a)
  );

  word_sequencer #(.NUM_WORDS(24)) dut_b (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .mode_random(mode_random), .next_char(next_char),
    .rom_addr(rom_addr_b), .rom_data(rom_data_b), .rom_len(rom_len_b),
    .cur_char(cur_char_b), .chars_left(chars_left_b), .num_char(num_char_b),
    .word_valid(word_valid_b), .word_done(word_done_b), .busy(busy_b),
    .word_index(word_index_b)
  );

  // One-cycle-latency ROMs
  always @(posedge clk) begin
    rom_data_a <= mem_data[rom_addr_a];
    rom_len_a  <= mem_len[rom_addr_a];
    rom_data_b <= {3'b000, rom_addr_b, 88'h0};
    rom_len_b  <= 4'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Bounded wait for dut_a to present a word; a timeout is a failed check.
  task automatic wait_valid(input string tag, input int budget);
    for (int n = 0; n < budget && !word_valid_a; n++) step();
    check(tag, word_valid_a, 1'b1);
  endtask

  int busy_cycles;
  logic [AW-1:0] prev_a, prev_b;

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem_data[i] = '0;
      mem_len[i]  = 4'd1;
    end
    mem_data[0] = {8'h24, 8'h21, 8'h2B, 72'h0};
    mem_len[0]  = 4'd3;
    mem_data[1] = {8'h41, 8'h42, 80'h0};
    mem_len[1]  = 4'd2;

    step(); step();
    reset = 1'b0;
    step();
    $display("reset released");
    check("rst_valid", word_valid_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_index", word_index_a, 0);
    check("rst_addr", rom_addr_a, 0);
    check("rst_left", chars_left_a, 0);
    check("rst_num", num_char_a, 0);
    check("rst_done", word_done_a, 1'b0);
    check("rst_cur", cur_char_a, 0);

    // Sequential read of word 0
    pulse_start();
    check("w0_busy1", busy_a, 1'b1);
    step();
    check("w0_busy2", busy_a, 1'b1);
    step();
    check("w0_busy_off", busy_a, 1'b0);
    check("w0_valid", word_valid_a, 1'b1);
    check("w0_cur0", cur_char_a, 8'h24);
    check("w0_left3", chars_left_a, 3);
    check("w0_num", num_char_a, 3);
    next_char = 1'b1;
    step();
    check("w0_cur1", cur_char_a, 8'h21);
    check("w0_left2", chars_left_a, 2);
    check("w0_nodone", word_done_a, 1'b0);
    step();
    check("w0_cur2", cur_char_a, 8'h2B);
    check("w0_left1", chars_left_a, 1);
    step();
    next_char = 1'b0;
    check("w0_cur3", cur_char_a, 8'h00);
    check("w0_left0", chars_left_a, 0);
    check("w0_done", word_done_a, 1'b1);
    check("w0_index", word_index_a, 1);
    check("w0_invalid", word_valid_a, 1'b0);
    step();
    check("w0_done_once", word_done_a, 1'b0);
    check("w0_num_hold", num_char_a, 3);
    $display("word 0 read, index now %0d", word_index_a);

    // next_char in DONE is ignored
    next_char = 1'b1;
    step();
    next_char = 1'b0;
    check("done_nc_left", chars_left_a, 0);
    check("done_nc_num", num_char_a, 3);
    check("done_nc_index", word_index_a, 1);
    check("done_nc_pulse", word_done_a, 1'b0);

    // Word 1: start ignored in ACTIVE, then abort with next_char
    pulse_start();
    check("w1_num_clr", num_char_a, 0);
    step(); step();
    check("w1_cur", cur_char_a, 8'h41);
    start = 1'b1;
    step();
    start = 1'b0;
    check("act_start_valid", word_valid_a, 1'b1);
    check("act_start_busy", busy_a, 1'b0);
    check("act_start_left", chars_left_a, 2);
    abort = 1'b1;
    next_char = 1'b1;
    step();
    abort = 1'b0;
    next_char = 1'b0;
    check("abort_valid", word_valid_a, 1'b0);
    check("abort_left", chars_left_a, 0);
    check("abort_num", num_char_a, 0);
    check("abort_index", word_index_a, 1);
    check("abort_cur", cur_char_a, 0);
    $display("word 1 aborted");

    // Complete word 1 to reach index 2
    pulse_start();
    wait_valid("w1b_valid", 10);
    next_char = 1'b1;
    step(); step();
    next_char = 1'b0;
    check("w1b_index", word_index_a, 2);

    // Skip: entry 2 empty, entry 3 loads after four busy cycles
    mem_len[2]  = 4'd0;
    mem_data[3] = {8'h55, 88'h0};
    mem_len[3]  = 4'd1;
    pulse_start();
    busy_cycles = 0;
    while (busy_a && busy_cycles < 20) begin
      busy_cycles++;
      step();
    end
    check("skip_busy_cycles", busy_cycles, 4);
    check("skip_index", word_index_a, 3);
    check("skip_addr", rom_addr_a, 3);
    check("skip_cur", cur_char_a, 8'h55);
    next_char = 1'b1;
    step();
    next_char = 1'b0;
    check("skip_next_index", word_index_a, 4);
    $display("skip over entry 2 loaded entry 3");

    // Wrap and clamp: entries 4..30 empty, entry 31 length 15
    for (int i = 4; i < 31; i++) mem_len[i] = 4'd0;
    mem_data[31] = {12{8'h77}};
    mem_len[31]  = 4'd15;
    pulse_start();
    wait_valid("wrap_valid", 80);
    check("wrap_load_index", word_index_a, 31);
    check("clamp_num", num_char_a, 12);
    check("clamp_left", chars_left_a, 12);
    check("clamp_cur", cur_char_a, 8'h77);
    next_char = 1'b1;
    for (int i = 0; i < 12; i++) step();
    next_char = 1'b0;
    check("wrap_index", word_index_a, 0);
    check("wrap_done", word_done_a, 1'b1);
    check("wrap_left", chars_left_a, 0);
    $display("entry 31 consumed, index wrapped to %0d", word_index_a);

    // All entries empty: a full lap of skips ends in IDLE
    for (int i = 0; i < 32; i++) mem_len[i] = 4'd0;
    pulse_start();
    busy_cycles = 0;
    while (busy_a && busy_cycles < 100) begin
      busy_cycles++;
      step();
    end
    check("allskip_busy", busy_a, 1'b0);
    check("allskip_valid", word_valid_a, 1'b0);
    check("allskip_index", word_index_a, 0);
    check("allskip_cycles", busy_cycles, 64);
    $display("all-empty list returned to idle");

    // Async reset mid-word
    mem_data[0] = {8'h11, 88'h0};
    mem_len[0]  = 4'd1;
    mem_data[1] = {8'h31, 8'h32, 8'h33, 72'h0};
    mem_len[1]  = 4'd3;
    pulse_start();
    wait_valid("ar_w0_valid", 10);
    check("ar_w0_cur", cur_char_a, 8'h11);
    next_char = 1'b1;
    step();
    next_char = 1'b0;
    pulse_start();
    wait_valid("ar_w1_valid", 10);
    next_char = 1'b1;
    step();
    next_char = 1'b0;
    check("ar_pre_left", chars_left_a, 2);
    check("ar_pre_index", word_index_a, 1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("ar_valid", word_valid_a, 1'b0);
    check("ar_left", chars_left_a, 0);
    check("ar_num", num_char_a, 0);
    check("ar_cur", cur_char_a, 0);
    check("ar_index", word_index_a, 0);
    check("ar_addr", rom_addr_a, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    $display("async reset mid-word cleared outputs");

    // Random order, both list sizes
    for (int i = 0; i < 32; i++) mem_len[i] = 4'd1;
    mode_random = 1'b1;
    prev_a = '0;
    prev_b = '0;
    for (int w = 0; w < 64; w++) begin
      pulse_start();
      wait_valid("rnd_valid_a", 10);
      check("rnd_valid_b", word_valid_b, 1'b1);
      if (w == 0) begin
        check("rnd_first_a", word_index_a, 0);
        check("rnd_first_b", word_index_b, 0);
      end else begin
        check("rnd_norepeat_a", word_index_a != prev_a, 1'b1);
        check("rnd_norepeat_b", word_index_b != prev_b, 1'b1);
      end
      check("rnd_range_a", word_index_a < 32, 1'b1);
      check("rnd_range_b", word_index_b < 24, 1'b1);
      check("rnd_cur_b", cur_char_b, {3'b000, word_index_b});
      $display("random word %0d: index_a %0d index_b %0d", w, word_index_a, word_index_b);
      prev_a = word_index_a;
      prev_b = word_index_b;
      next_char = 1'b1;
      step();
      next_char = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
